// File: rtl/mem_loader.sv
// Copies input and kernel words from a source memory into an internal memory
// through paired address/data valid-ready channels, one word at a time.
module mem_loader #(
    parameter int IO_DATA_WIDTH    = 16,
    parameter int SRC_ADDR_WIDTH   = 16,
    parameter int MAX_INPUT_WORDS  = 32768,
    parameter int MAX_KERNEL_WORDS = 512
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      start,
    input  logic [15:0]               n_input_words,
    input  logic [9:0]                n_kernel_words,
    output logic                      src_read_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_read_addr,
    input  logic [IO_DATA_WIDTH-1:0]  src_qout,
    output logic [IO_DATA_WIDTH-1:0]  a_input,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [IO_DATA_WIDTH-1:0]  b_input,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic                      int_mem_we,
    output logic                      data_ready,
    output logic                      busy,
    output logic                      done
);

    // Counters hold MAX+1 so the "next index" compare never wraps.
    localparam int CW_IN = $clog2(MAX_INPUT_WORDS + 1);
    localparam int CW_K  = $clog2(MAX_KERNEL_WORDS + 1);
    localparam int CW    = (CW_IN > CW_K) ? CW_IN : CW_K;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]                state;
    logic [CW_IN-1:0]          n_in_q;
    logic [CW_K-1:0]           n_k_q;
    logic [CW-1:0]             idx;
    logic                      kern;

    logic [CW_IN-1:0]          n_in_cl;
    logic [CW_K-1:0]           n_k_cl;
    logic [CW-1:0]             idx_inc;
    logic                      last_word;
    logic                      xfer;
    logic [IO_DATA_WIDTH-1:0]  a_next;
    logic [SRC_ADDR_WIDTH-1:0] src_addr_next;

    always_comb begin
        n_in_cl = (32'(n_input_words) > MAX_INPUT_WORDS) ? CW_IN'(MAX_INPUT_WORDS)
                                                         : CW_IN'(n_input_words);
        n_k_cl  = (32'(n_kernel_words) > MAX_KERNEL_WORDS) ? CW_K'(MAX_KERNEL_WORDS)
                                                           : CW_K'(n_kernel_words);
    end

    assign idx_inc   = idx + CW'(1);
    assign last_word = kern ? (idx_inc >= CW'(n_k_q)) : (idx_inc >= CW'(n_in_q));

    // Kernel words sit right after the latched input words in source memory.
    assign src_addr_next = kern ? SRC_ADDR_WIDTH'(n_in_q) + SRC_ADDR_WIDTH'(idx)
                                : SRC_ADDR_WIDTH'(idx);

    always_comb begin
        a_next = '0;
        if (kern) begin
            a_next[15]  = 1'b1;
            a_next[8:0] = 9'(idx);
        end else begin
            a_next[14:0] = 15'(idx);
        end
    end

    assign src_read_en   = (state == S_FETCH);
    assign src_read_addr = src_read_en ? src_addr_next : '0;
    assign a_valid       = (state == S_SEND);
    assign b_valid       = (state == S_SEND);
    assign xfer          = a_valid & a_ready & b_valid & b_ready;
    assign int_mem_we    = xfer;
    assign busy          = (state == S_FETCH) || (state == S_WAIT) || (state == S_SEND);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= S_IDLE;
            n_in_q     <= '0;
            n_k_q      <= '0;
            idx        <= '0;
            kern       <= 1'b0;
            a_input    <= '0;
            b_input    <= '0;
            data_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_in_q     <= n_in_cl;
                        n_k_q      <= n_k_cl;
                        idx        <= '0;
                        kern       <= (n_in_cl == '0);
                        data_ready <= 1'b0;
                        state      <= ((n_in_cl == '0) && (n_k_cl == '0)) ? S_FINISH : S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    b_input <= src_qout;
                    a_input <= a_next;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (!last_word) begin
                            idx   <= idx_inc;
                            state <= S_FETCH;
                        end else if (!kern && (n_k_q != '0)) begin
                            kern  <= 1'b1;
                            idx   <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    done       <= 1'b1;
                    data_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameters: IO_DATA_WIDTH, default 16, word width; SRC_ADDR_WIDTH, default 16, source memory address width; MAX_INPUT_WORDS, default 32768, input memory depth; MAX_KERNEL_WORDS, default 512, kernel memory depth.
REQ-002 SHALL have ports as listed in REQ-003 to REQ-018, clock and reset first: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 rst_in  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle request to begin a load.
REQ-006 n_input_words  in  16  input words to send, sampled at accepted start.
REQ-007 n_kernel_words  in  10  kernel words to send, sampled at accepted start.
REQ-008 src_read_en  out  1  source memory read strobe.
REQ-009 src_read_addr  out  SRC_ADDR_WIDTH  source memory read address.
REQ-010 src_qout  in  IO_DATA_WIDTH  source read data, valid exactly 1 cycle after src_read_en.
REQ-011 a_input  out  IO_DATA_WIDTH  target address; bit 15 = 1 kernel, 0 input; input words use [14:0], kernel words use [8:0].
REQ-012 a_valid / a_ready  out / in  1 / 1  address channel handshake.
REQ-013 b_input  out  IO_DATA_WIDTH  data word.
REQ-014 b_valid / b_ready  out / in  1 / 1  data channel handshake.
REQ-015 int_mem_we  out  1  internal memory write enable, high only in transfer cycles.
REQ-016 data_ready  out  1  level, all words loaded.
REQ-017 busy  out  1  load in progress.
REQ-018 done  out  1  one-cycle pulse at load completion.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, WAIT_DATA, SEND, FINISH.
REQ-020 In IDLE, start=1 SHALL be accepted: latch the counts, clear data_ready, and go to FETCH; if both latched counts are 0, go directly to FINISH.
REQ-021 Counts above MAX_INPUT_WORDS or MAX_KERNEL_WORDS SHALL be clamped to the maximum at latch time.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 FETCH SHALL assert src_read_en for exactly 1 cycle, then go to WAIT_DATA.
REQ-024 Source layout: input word i SHALL be read at src addr i; kernel word j at src addr n_input_words+j (latched value).
REQ-025 WAIT_DATA SHALL capture src_qout into the b_input register and go to SEND.
REQ-026 In SEND, a_valid and b_valid SHALL both be 1, with a_input and b_input held stable until transfer.
REQ-027 A transfer SHALL occur only in a cycle with a_valid & a_ready & b_valid & b_ready; readies seen in different cycles SHALL NOT transfer.
REQ-028 int_mem_we SHALL equal 1 exactly in transfer cycles, so exactly one pulse per word.
REQ-029 Valids SHALL NOT deassert before transfer; after transfer they SHALL drop next cycle and the FSM goes to FETCH, or to FINISH after the last word.
REQ-030 Order: all input words (addr 0..N-1, bit15=0), then all kernel words (addr 0..K-1, bit15=1); a_input[14:9] SHALL be 0 for kernel words.
REQ-031 Throughput: one word per 3 cycles when readies are held high; start to first a_valid is 3 cycles.
REQ-032 FINISH SHALL pulse done for 1 cycle, set data_ready=1, and go to IDLE; data_ready SHALL stay 1 until the next accepted start or rst_in.
REQ-033 busy SHALL be 1 in FETCH, WAIT_DATA and SEND; 0 in IDLE and FINISH.
REQ-034 Word counters SHALL be wide enough to hold MAX count+1 without wrap.

Reset
REQ-035 rst_in=1 SHALL force IDLE and set every output to 0 (including data_ready, int_mem_we and the valids) on the next edge, regardless of state.
REQ-036 Reset mid-transfer SHALL abandon the load; a subsequent start SHALL restart from input word 0.

Verification
REQ-037 N=2, K=1, readies tied 1, src[0..2]=0x11,0x22,0x33 -> three int_mem_we pulses: (a=0x0000, b=0x0011), (0x0001, 0x0022), (0x8000, 0x0033); then done pulse and data_ready=1.
REQ-038 N=1, K=0, a_ready=1, b_ready held 0 for 5 cycles -> a_valid, b_valid, a_input, b_input stable; no int_mem_we until b_ready=1.
REQ-039 N=0, K=0, start -> no src_read_en; done pulses 2 cycles after start; data_ready=1.
REQ-040 N=40000, K=600 -> exactly 32768+512 transfers; last kernel a_input=0x81FF.
REQ-041 rst_in asserted during SEND of word 5 -> all outputs 0 next cycle; restart sends word 0 first.
REQ-042 start pulsed again while busy -> ignored; transfer count unchanged.
